// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sampler.
// Holds the FSM state encoding and the table-width helpers.
package tt_pkg;

    localparam int STATE_W  = 2;
    localparam int TT_N_DEF = 3;
    localparam int TBL_W    = 1 << TT_N_DEF;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } tt_state_e;

    function automatic int tbl_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_index_counter.sv
// Input-vector counter with a per-vector settle phase counter.
// Each vector is held SETTLE+1 cycles; sample_now marks the last of them.
module tt_index_counter
    import tt_pkg::*;
#(
    parameter int N      = TT_N_DEF,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         run,
    output logic [N-1:0] vec,
    output logic         settle_done,
    output logic         sample_now,
    output logic         last_vec
);

    localparam int PH_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [PH_W-1:0] PH_MAX = PH_W'(SETTLE);
    localparam logic [PH_W-1:0] PH_PRE = PH_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    logic [PH_W-1:0] ph;

    assign last_vec    = (vec == {N{1'b1}});
    assign sample_now  = run && (ph == PH_MAX);
    // Asserted on the final settle cycle so the FSM enters SAMPLE exactly when ph hits PH_MAX.
    assign settle_done = (SETTLE > 0) && run && (ph == PH_PRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec <= '0;
            ph  <= '0;
        end else if (clear) begin
            vec <= '0;
            ph  <= '0;
        end else if (run) begin
            if (ph == PH_MAX) begin
                ph <= '0;
                // The counter parks on the last vector; only a new scan returns it to 0.
                if (!last_vec) begin
                    vec <= vec + 1'b1;
                end
            end else begin
                ph <= ph + 1'b1;
            end
        end
    end

endmodule

// File: rtl/truth_table_sampler.sv
// Sweeps a combinational function through all 2^N input vectors, captures
// its truth table and compares it against a reference table.
module truth_table_sampler
    import tt_pkg::*;
#(
    parameter int N      = TT_N_DEF,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [(1<<N)-1:0]   expected,
    output logic [N-1:0]        vec,
    input  logic                s_in,
    output logic                busy,
    output logic                done,
    output logic [(1<<N)-1:0]   table_out,
    output logic                match,
    output logic [N:0]          mismatch_cnt,
    output logic [N-1:0]        first_bad
);

    localparam int TW = tbl_width(N);

    tt_state_e state, state_nxt;

    logic          accept;
    logic          run;
    logic          finish;
    logic          settle_done;
    logic          sample_now;
    logic          last_vec;
    logic [TW-1:0] exp_q;

    tt_index_counter #(
        .N      (N),
        .SETTLE (SETTLE)
    ) u_index (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (accept),
        .run         (run),
        .vec         (vec),
        .settle_done (settle_done),
        .sample_now  (sample_now),
        .last_vec    (last_vec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_done) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (last_vec) begin
                    state_nxt = ST_FINISH;
                end else if (SETTLE != 0) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // done is still high in the first IDLE cycle after a scan; a start there is dropped.
    always_comb begin
        accept = (state == ST_IDLE) && start && !done;
        run    = (state == ST_SETTLE) || (state == ST_SAMPLE);
        finish = (state == ST_FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q        <= '0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            first_bad    <= '0;
            match        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                exp_q        <= expected;
                table_out    <= '0;
                mismatch_cnt <= '0;
                first_bad    <= '0;
                match        <= 1'b0;
                busy         <= 1'b1;
            end
            if (sample_now) begin
                table_out[vec] <= s_in;
                if (s_in != exp_q[vec]) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                    if (mismatch_cnt == '0) begin
                        first_bad <= vec;
                    end
                end
            end
            if (finish) begin
                busy  <= 1'b0;
                match <= (table_out == exp_q);
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sampler.sv
// Bench for truth_table_sampler: three configurations driven by directed scans,
// checked every cycle against a table-level model plus literal expectations.
module tb_truth_table_sampler;

    localparam int NN [3] = '{3, 3, 2};
    localparam int SS [3] = '{1, 0, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_v  [3];
    logic       start_v  [3];
    logic [7:0] exp_v    [3];
    int         mode_v   [3];
    logic       s_v      [3];

    logic [2:0] o_vec    [3];
    logic [7:0] o_tbl    [3];
    logic [3:0] o_cnt    [3];
    logic [2:0] o_fb     [3];
    logic       o_busy   [3];
    logic       o_done   [3];
    logic       o_match  [3];

    logic [1:0] vec_c, fb_c;
    logic [3:0] tbl_c;
    logic [2:0] cnt_c;

    int n_checks = 0;
    int n_err    = 0;

    bit         m_act   [3];
    bit         m_done  [3];
    bit         m_busy  [3];
    bit         m_match [3];
    int         m_k     [3];
    int         m_cnt   [3];
    int         m_fb    [3];
    int         m_vec   [3];
    logic [7:0] m_exp   [3];
    logic [7:0] m_tbl   [3];

    function automatic logic fn(input int mode, input logic [2:0] v);
        case (mode)
            0:       return v[2] & ~v[1] & v[0];
            1:       return 1'b1;
            default: return v[1] ^ v[0];
        endcase
    endfunction

    assign s_v[0] = fn(mode_v[0], o_vec[0]);
    assign s_v[1] = fn(mode_v[1], o_vec[1]);
    assign s_v[2] = fn(mode_v[2], o_vec[2]);

    assign o_vec[2] = {1'b0, vec_c};
    assign o_tbl[2] = {4'b0, tbl_c};
    assign o_cnt[2] = {1'b0, cnt_c};
    assign o_fb[2]  = {1'b0, fb_c};

    truth_table_sampler #(.N(3), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]), .expected(exp_v[0]),
        .vec(o_vec[0]), .s_in(s_v[0]), .busy(o_busy[0]), .done(o_done[0]),
        .table_out(o_tbl[0]), .match(o_match[0]), .mismatch_cnt(o_cnt[0]), .first_bad(o_fb[0])
    );

    truth_table_sampler #(.N(3), .SETTLE(0)) dut_b (
        .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]), .expected(exp_v[1]),
        .vec(o_vec[1]), .s_in(s_v[1]), .busy(o_busy[1]), .done(o_done[1]),
        .table_out(o_tbl[1]), .match(o_match[1]), .mismatch_cnt(o_cnt[1]), .first_bad(o_fb[1])
    );

    truth_table_sampler #(.N(2), .SETTLE(2)) dut_c (
        .clk(clk), .rst_n(rst_n_v[2]), .start(start_v[2]), .expected(exp_v[2][3:0]),
        .vec(vec_c), .s_in(s_v[2]), .busy(o_busy[2]), .done(o_done[2]),
        .table_out(tbl_c), .match(o_match[2]), .mismatch_cnt(cnt_c), .first_bad(fb_c)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Model: after k edges since an accepted start, vector j has been sampled
    // once (j+1)*(SETTLE+1) <= k; done arrives at k = 2^N*(SETTLE+1)+1.
    task automatic model_step(input int d);
        int per, ntab, lat, c, f;
        bit found;
        logic [7:0] t;
        per  = SS[d] + 1;
        ntab = 1 << NN[d];
        lat  = ntab * per + 1;
        t = '0; c = 0; f = 0; found = 0;
        for (int j = 0; j < ntab; j++) begin
            if ((j + 1) * per <= m_k[d]) begin
                t[j] = fn(mode_v[d], 3'(j));
                if (t[j] != m_exp[d][j]) begin
                    c++;
                    if (!found) begin
                        f = j;
                        found = 1;
                    end
                end
            end
        end
        m_tbl[d] = t;
        m_cnt[d] = c;
        m_fb[d]  = f;
        m_vec[d] = (m_k[d] / per < ntab) ? m_k[d] / per : ntab - 1;
        if (m_k[d] == lat) begin
            m_done[d]  = 1;
            m_busy[d]  = 0;
            m_act[d]   = 0;
            m_match[d] = (t == m_exp[d]);
        end
    endtask

    task automatic model_edge(input int d);
        bit old_done;
        if (!rst_n_v[d]) begin
            m_act[d] = 0; m_done[d] = 0; m_busy[d] = 0; m_match[d] = 0;
            m_k[d] = 0; m_cnt[d] = 0; m_fb[d] = 0; m_vec[d] = 0; m_tbl[d] = '0;
        end else begin
            old_done  = m_done[d];
            m_done[d] = 0;
            if (m_act[d]) begin
                m_k[d]++;
                model_step(d);
            end else if (start_v[d] && !old_done) begin
                m_act[d]   = 1;
                m_k[d]     = 0;
                m_exp[d]   = exp_v[d] & 8'((1 << (1 << NN[d])) - 1);
                m_tbl[d]   = '0;
                m_cnt[d]   = 0;
                m_fb[d]    = 0;
                m_match[d] = 0;
                m_busy[d]  = 1;
                m_vec[d]   = 0;
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_act[d] = 0; m_done[d] = 0; m_busy[d] = 0; m_match[d] = 0;
            m_k[d] = 0; m_cnt[d] = 0; m_fb[d] = 0; m_vec[d] = 0;
            m_tbl[d] = '0; m_exp[d] = '0;
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) model_edge(d);
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst_n_v[d]) begin
                chk($sformatf("d%0d vec", d),       int'(o_vec[d]),   m_vec[d]);
                chk($sformatf("d%0d busy", d),      int'(o_busy[d]),  int'(m_busy[d]));
                chk($sformatf("d%0d done", d),      int'(o_done[d]),  int'(m_done[d]));
                chk($sformatf("d%0d table_out", d), int'(o_tbl[d]),   int'(m_tbl[d]));
                chk($sformatf("d%0d mismatch", d),  int'(o_cnt[d]),   m_cnt[d]);
                chk($sformatf("d%0d first_bad", d), int'(o_fb[d]),    m_fb[d]);
                chk($sformatf("d%0d match", d),     int'(o_match[d]), int'(m_match[d]));
            end
        end
    end

    task automatic chk_reset(input int d, input string tag);
        chk($sformatf("%s d%0d vec", tag, d),       int'(o_vec[d]),   0);
        chk($sformatf("%s d%0d busy", tag, d),      int'(o_busy[d]),  0);
        chk($sformatf("%s d%0d done", tag, d),      int'(o_done[d]),  0);
        chk($sformatf("%s d%0d table_out", tag, d), int'(o_tbl[d]),   0);
        chk($sformatf("%s d%0d mismatch", tag, d),  int'(o_cnt[d]),   0);
        chk($sformatf("%s d%0d first_bad", tag, d), int'(o_fb[d]),    0);
        chk($sformatf("%s d%0d match", tag, d),     int'(o_match[d]), 0);
    endtask

    task automatic run_scan(input int d, input logic [7:0] e, output int lat);
        @(negedge clk);
        exp_v[d]   = e;
        start_v[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[d] = 1'b0;
        lat = 0;
        while (!o_done[d] && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!o_done[d]) begin
            n_checks++;
            n_err++;
            $display("FAIL d%0d done timeout after %0d cycles", d, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int lat, pulses;
        for (int d = 0; d < 3; d++) begin
            rst_n_v[d] = 1'b0;
            start_v[d] = 1'b0;
            exp_v[d]   = '0;
        end
        mode_v[0] = 0;
        mode_v[1] = 1;
        mode_v[2] = 2;

        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk_reset(d, "reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst_n_v[d] = 1'b1;

        // x & ~y & z is true only for vector 5
        run_scan(0, 8'h20, lat);
        chk("t1 latency", lat, 17);
        chk("t1 table", int'(o_tbl[0]), 32'h20);
        chk("t1 match", int'(o_match[0]), 1);
        chk("t1 mismatch", int'(o_cnt[0]), 0);

        run_scan(0, 8'h24, lat);
        chk("t2 latency", lat, 17);
        chk("t2 match", int'(o_match[0]), 0);
        chk("t2 mismatch", int'(o_cnt[0]), 1);
        chk("t2 first_bad", int'(o_fb[0]), 2);

        run_scan(1, 8'h00, lat);
        chk("t3 latency", lat, 9);
        chk("t3 table", int'(o_tbl[1]), 32'hFF);
        chk("t3 mismatch", int'(o_cnt[1]), 8);
        chk("t3 first_bad", int'(o_fb[1]), 0);

        // extra starts mid-scan and in the done cycle must be dropped
        @(negedge clk);
        exp_v[0]   = 8'h20;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        exp_v[0]   = 8'hFF;
        pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            start_v[0] = (c == 5);
            if (o_done[0]) begin
                pulses++;
                start_v[0] = 1'b1;
                chk("t4 done cycle", c, 17);
            end
        end
        start_v[0] = 1'b0;
        chk("t4 done pulses", pulses, 1);
        chk("t4 table", int'(o_tbl[0]), 32'h20);
        chk("t4 match", int'(o_match[0]), 1);
        chk("t4 busy", int'(o_busy[0]), 0);
        exp_v[0] = 8'h20;

        // mid-scan asynchronous reset with s_in tied high
        mode_v[0] = 1;
        exp_v[0]  = 8'h00;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t5 partial table", int'(o_tbl[0]), 32'h07);
        chk("t5 partial mismatch", int'(o_cnt[0]), 3);
        #1;
        rst_n_v[0] = 1'b0;
        #1;
        chk_reset(0, "t5 async");
        @(posedge clk);
        @(negedge clk);
        rst_n_v[0] = 1'b1;
        mode_v[0] = 0;
        run_scan(0, 8'h20, lat);
        chk("t5 rescan latency", lat, 17);
        chk("t5 rescan table", int'(o_tbl[0]), 32'h20);
        chk("t5 rescan match", int'(o_match[0]), 1);

        run_scan(2, 8'h06, lat);
        chk("t6 latency", lat, 13);
        chk("t6 table", int'(o_tbl[2]), 32'h6);
        chk("t6 match", int'(o_match[2]), 1);
        chk("t6 mismatch", int'(o_cnt[2]), 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
